// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and debounces encoder phases A/B, then drives
// a wrapping up/down position counter with direction, step strobe and sticky error.
module quad_decoder #(
  parameter int WIDTH = 8,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en_load,
  input  logic [WIDTH-1:0] load,
  input  logic             clr_err,
  output logic [WIDTH-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

  // Channel vectors: bit 0 = phase A, bit 1 = phase B.
  logic [1:0]       r_s1;
  logic [1:0]       r_s2;
  logic [1:0]       r_f;
  logic [1:0]       r_p;
  logic [CW-1:0]    r_cnt_a;
  logic [CW-1:0]    r_cnt_b;
  logic [WIDTH-1:0] r_pos;
  logic             r_dir;
  logic             r_step;
  logic             r_err;

  logic [1:0] w_cur_idx;
  logic [1:0] w_prev_idx;
  logic [1:0] w_delta;
  logic       w_up;
  logic       w_dn;
  logic       w_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_p  <= '0;
    end else begin
      r_s1 <= {b_in, a_in};
      r_s2 <= r_s1;
      r_p  <= r_f;
    end
  end

  // A change is accepted only after s2 has disagreed for FILT consecutive edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f     <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (r_s2[0] == r_f[0]) begin
        r_cnt_a <= '0;
      end else if (r_cnt_a == CNT_MAX) begin
        r_f[0]  <= r_s2[0];
        r_cnt_a <= '0;
      end else begin
        r_cnt_a <= r_cnt_a + CW'(1);
      end

      if (r_s2[1] == r_f[1]) begin
        r_cnt_b <= '0;
      end else if (r_cnt_b == CNT_MAX) begin
        r_f[1]  <= r_s2[1];
        r_cnt_b <= '0;
      end else begin
        r_cnt_b <= r_cnt_b + CW'(1);
      end
    end
  end

  // Map the gray sequence 00,10,11,01 (A,B) onto 0..3 so a step is a +/-1 difference.
  always_comb begin
    w_cur_idx  = {r_f[1], r_f[0] ^ r_f[1]};
    w_prev_idx = {r_p[1], r_p[0] ^ r_p[1]};
    w_delta    = w_cur_idx - w_prev_idx;
    w_up       = (w_delta == 2'd1);
    w_dn       = (w_delta == 2'd3);
    w_bad      = (w_delta == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos  <= '0;
      r_dir  <= 1'b0;
      r_step <= 1'b0;
    end else if (en_load) begin
      r_pos  <= load;
      r_step <= 1'b0;
    end else begin
      r_step <= w_up | w_dn;
      if (w_up) begin
        r_pos <= r_pos + WIDTH'(1);
        r_dir <= 1'b1;
      end else if (w_dn) begin
        r_pos <= r_pos - WIDTH'(1);
        r_dir <= 1'b0;
      end
    end
  end

  // A new illegal jump beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

  assign pos  = r_pos;
  assign dir  = r_dir;
  assign step = r_step;
  assign err  = r_err;

endmodule
